sc_regshf_autoshift: RTL and testbench

- Parametrised successor of the game-board loadable rotate register.
- Adds variable width, four shift modes (rotate or logical shift, left or right), and a multi-step command engine.
- A single start pulse performs N single-bit steps, spaced by a programmable prescaler, then signals done.
- Used by game logic for timed scrolling and animation of board rows without per-cycle control from the FSM.

---
 rtl/sc_regshf_autoshift.sv | 160 ++++++++++++++++
 tb/tb_sc_regshf_autoshift.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/sc_regshf_autoshift.sv
// Loadable W-bit rotate/shift register with a multi-step command engine.
// A start pulse runs N single-bit steps spaced P+1 cycles apart, then pulses done.
module sc_regshf_autoshift #(
   parameter int RegSHF_DATAWIDTH = 8,
   parameter int RegSHF_STEPWIDTH = 3,
   parameter int RegSHF_TICKWIDTH = 4,
   parameter logic [RegSHF_DATAWIDTH-1:0] DATA_FIXED_INITREGPOINT = '0
) (
   input  logic                        SC_RegSHF_CLOCK_50,
   input  logic                        SC_RegSHF_RESET_InHigh,
   input  logic                        SC_RegSHF_clear_InLow,
   input  logic                        SC_RegSHF_load0_InLow,
   input  logic                        SC_RegSHF_load1_InLow,
   input  logic [RegSHF_DATAWIDTH-1:0] SC_RegSHF_data0_InBUS,
   input  logic [RegSHF_DATAWIDTH-1:0] SC_RegSHF_data1_InBUS,
   input  logic [1:0]                  SC_RegSHF_mode_In,
   input  logic                        SC_RegSHF_serial_In,
   input  logic [RegSHF_STEPWIDTH-1:0] SC_RegSHF_steps_In,
   input  logic [RegSHF_TICKWIDTH-1:0] SC_RegSHF_period_In,
   input  logic                        SC_RegSHF_start_InLow,
   input  logic                        SC_RegSHF_abort_InLow,
   output logic [RegSHF_DATAWIDTH-1:0] SC_RegSHF_data_OutBUS,
   output logic                        SC_RegSHF_busy_Out,
   output logic                        SC_RegSHF_done_Out,
   output logic                        SC_RegSHF_serial_Out,
   output logic                        SC_RegSHF_zero_Out
);

   localparam int W = RegSHF_DATAWIDTH;
   localparam logic [RegSHF_STEPWIDTH-1:0] STEP_ONE = 1;
   localparam logic [RegSHF_TICKWIDTH-1:0] TICK_ONE = 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t                      state_q, state_d;
   logic [W-1:0]                data_q, data_d;
   logic                        serial_q, serial_d;
   logic [1:0]                  mode_q, mode_d;
   logic [RegSHF_TICKWIDTH-1:0] period_q, period_d;
   logic [RegSHF_TICKWIDTH-1:0] tick_q, tick_d;
   logic [RegSHF_STEPWIDTH-1:0] step_q, step_d;

   logic [W-1:0] shl_val;
   logic [W-1:0] shr_val;
   logic [W-1:0] step_val;
   logic         step_bit;

   // mode[1] selects serial fill instead of wrap-around; mode[0] selects right.
   assign shl_val[0]   = mode_q[1] ? SC_RegSHF_serial_In : data_q[W-1];
   assign shr_val[W-1] = mode_q[1] ? SC_RegSHF_serial_In : data_q[0];

   genvar gi;
   generate
      for (gi = 1; gi < W; gi++) begin : g_shift
         assign shl_val[gi]   = data_q[gi-1];
         assign shr_val[gi-1] = data_q[gi];
      end
   endgenerate

   assign step_val = mode_q[0] ? shr_val : shl_val;
   assign step_bit = mode_q[0] ? data_q[0] : data_q[W-1];

   always_comb begin
      state_d  = state_q;
      data_d   = data_q;
      serial_d = serial_q;
      mode_d   = mode_q;
      period_d = period_q;
      tick_d   = tick_q;
      step_d   = step_q;

      if (!SC_RegSHF_clear_InLow || !SC_RegSHF_load0_InLow || !SC_RegSHF_load1_InLow) begin
         if (!SC_RegSHF_clear_InLow) begin
            data_d = DATA_FIXED_INITREGPOINT;
         end else if (!SC_RegSHF_load0_InLow) begin
            data_d = SC_RegSHF_data0_InBUS;
         end else begin
            data_d = SC_RegSHF_data1_InBUS;
         end
         state_d = ST_IDLE;
         tick_d  = '0;
         step_d  = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (!SC_RegSHF_start_InLow) begin
                  mode_d   = SC_RegSHF_mode_In;
                  period_d = SC_RegSHF_period_In;
                  if (SC_RegSHF_steps_In == '0) begin
                     state_d = ST_DONE;
                  end else begin
                     state_d = ST_RUN;
                     tick_d  = SC_RegSHF_period_In;
                     step_d  = SC_RegSHF_steps_In;
                  end
               end
            end
            ST_RUN: begin
               if (!SC_RegSHF_abort_InLow) begin
                  state_d = ST_IDLE;
                  tick_d  = '0;
                  step_d  = '0;
               end else if (tick_q == '0) begin
                  data_d   = step_val;
                  serial_d = step_bit;
                  if (step_q == STEP_ONE) begin
                     state_d = ST_DONE;
                     tick_d  = '0;
                     step_d  = '0;
                  end else begin
                     step_d = step_q - STEP_ONE;
                     tick_d = period_q;
                  end
               end else begin
                  tick_d = tick_q - TICK_ONE;
               end
            end
            ST_DONE: begin
               state_d = ST_IDLE;
            end
            default: begin
               state_d = ST_IDLE;
               tick_d  = '0;
               step_d  = '0;
            end
         endcase
      end
   end

   always_ff @(posedge SC_RegSHF_CLOCK_50) begin
      if (SC_RegSHF_RESET_InHigh) begin
         state_q  <= ST_IDLE;
         data_q   <= '0;
         serial_q <= 1'b0;
         mode_q   <= '0;
         period_q <= '0;
         tick_q   <= '0;
         step_q   <= '0;
      end else begin
         state_q  <= state_d;
         data_q   <= data_d;
         serial_q <= serial_d;
         mode_q   <= mode_d;
         period_q <= period_d;
         tick_q   <= tick_d;
         step_q   <= step_d;
      end
   end

   assign SC_RegSHF_data_OutBUS = data_q;
   assign SC_RegSHF_busy_Out    = (state_q == ST_RUN);
   assign SC_RegSHF_done_Out    = (state_q == ST_DONE);
   assign SC_RegSHF_serial_Out  = serial_q;
   assign SC_RegSHF_zero_Out    = (data_q == '0);

endmodule

// File: tb/tb_sc_regshf_autoshift.sv
// Scoreboard bench: stimulus queues per-edge expectations and done-pulse data;
// a negedge monitor pops and compares them against the register outputs.
module tb_sc_regshf_autoshift;

   logic       clk;
   logic       rst;
   logic       clear_n, load0_n, load1_n, start_n, abort_n;
   logic [7:0] d0, d1;
   logic [1:0] mode;
   logic       ser_in;
   logic [2:0] steps;
   logic [3:0] period;
   logic [7:0] data_out;
   logic       busy, done, ser_out, zero;

   sc_regshf_autoshift dut (
      .SC_RegSHF_CLOCK_50     (clk),
      .SC_RegSHF_RESET_InHigh (rst),
      .SC_RegSHF_clear_InLow  (clear_n),
      .SC_RegSHF_load0_InLow  (load0_n),
      .SC_RegSHF_load1_InLow  (load1_n),
      .SC_RegSHF_data0_InBUS  (d0),
      .SC_RegSHF_data1_InBUS  (d1),
      .SC_RegSHF_mode_In      (mode),
      .SC_RegSHF_serial_In    (ser_in),
      .SC_RegSHF_steps_In     (steps),
      .SC_RegSHF_period_In    (period),
      .SC_RegSHF_start_InLow  (start_n),
      .SC_RegSHF_abort_InLow  (abort_n),
      .SC_RegSHF_data_OutBUS  (data_out),
      .SC_RegSHF_busy_Out     (busy),
      .SC_RegSHF_done_Out     (done),
      .SC_RegSHF_serial_Out   (ser_out),
      .SC_RegSHF_zero_Out     (zero)
   );

   typedef struct {
      int         cyc;
      logic [7:0] data;
      logic       busy;
      logic       done;
      logic       ser;
      string      name;
   } exp_t;

   exp_t       exp_q[$];
   logic [7:0] done_q[$];
   int         edge_n = 0;
   int         n_checks = 0;
   int         n_fail = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      edge_n = edge_n + 1;
   end

   task automatic expect_at(input int cyc, input logic [7:0] dv, input logic b,
                            input logic dn, input logic s, input string nm);
      exp_t e;
      e.cyc = cyc; e.data = dv; e.busy = b; e.done = dn; e.ser = s; e.name = nm;
      exp_q.push_back(e);
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Monitor: checks state after each edge against queued expectations.
   initial begin
      exp_t       e;
      logic [7:0] dexp;
      logic [11:0] act, req;
      forever begin
         @(negedge clk);
         if (done === 1'b1) begin
            n_checks = n_checks + 1;
            if (done_q.size() == 0) begin
               n_fail = n_fail + 1;
               $display("FAIL done_pulse: unexpected done after edge %0d, data=%h, required no pulse",
                        edge_n, data_out);
            end else begin
               dexp = done_q.pop_front();
               if (data_out !== dexp) begin
                  n_fail = n_fail + 1;
                  $display("FAIL done_data: edge %0d data=%h, required %h", edge_n, data_out, dexp);
               end
            end
         end
         while (exp_q.size() > 0 && exp_q[0].cyc <= edge_n) begin
            e = exp_q.pop_front();
            n_checks = n_checks + 1;
            act = {data_out, busy, done, ser_out, zero};
            req = {e.data, e.busy, e.done, e.ser, (e.data == 8'h00)};
            if (e.cyc != edge_n || act !== req) begin
               n_fail = n_fail + 1;
               $display("FAIL %s: edge %0d data/busy/done/ser/zero=%h/%b/%b/%b/%b, required edge %0d %h/%b/%b/%b/%b",
                        e.name, edge_n, act[11:4], act[3], act[2], act[1], act[0],
                        e.cyc, req[11:4], req[3], req[2], req[1], req[0]);
            end else begin
               $display("check %s edge %0d data=%h busy=%b done=%b ser=%b zero=%b ok",
                        e.name, edge_n, data_out, busy, done, ser_out, zero);
            end
         end
      end
   end

   initial begin
      int k;
      rst = 1'b1; clear_n = 1'b1; load0_n = 1'b1; load1_n = 1'b1;
      start_n = 1'b0; abort_n = 1'b1; mode = 2'b00; ser_in = 1'b0;
      steps = 3'd0; period = 4'd0; d0 = 8'h00; d1 = 8'h00;

      // Reset for two edges with start held low
      expect_at(1, 8'h00, 0, 0, 0, "rst_e1");
      expect_at(2, 8'h00, 0, 0, 0, "rst_e2");
      tick(2);
      rst = 1'b0; start_n = 1'b1;
      expect_at(3, 8'h00, 0, 0, 0, "idle_after_rst");

      // Rotate left 0xA5 three steps, P=0
      tick(1);
      load0_n = 1'b0; d0 = 8'hA5; k = edge_n + 1;
      expect_at(k, 8'hA5, 0, 0, 0, "load_a5");
      tick(1);
      load0_n = 1'b1; start_n = 1'b0; mode = 2'b00; steps = 3'd3; period = 4'd0;
      k = edge_n + 1;
      expect_at(k,     8'hA5, 1, 0, 0, "rol_start");
      expect_at(k + 1, 8'h4B, 1, 0, 1, "rol_step1");
      expect_at(k + 2, 8'h96, 1, 0, 0, "rol_step2");
      expect_at(k + 3, 8'h2D, 0, 1, 1, "rol_done");
      expect_at(k + 4, 8'h2D, 0, 0, 1, "rol_idle");
      done_q.push_back(8'h2D);
      tick(1);
      start_n = 1'b1; mode = 2'b11; steps = 3'd7; period = 4'd9;
      tick(4);

      // Shift right with fill of 1, S=2, P=2; inputs changed mid-command
      load0_n = 1'b0; d0 = 8'h01; k = edge_n + 1;
      expect_at(k, 8'h01, 0, 0, 1, "load_01");
      tick(1);
      load0_n = 1'b1; start_n = 1'b0; mode = 2'b11; ser_in = 1'b1; steps = 3'd2; period = 4'd2;
      k = edge_n + 1;
      expect_at(k,     8'h01, 1, 0, 1, "shr_start");
      expect_at(k + 2, 8'h01, 1, 0, 1, "shr_wait");
      expect_at(k + 3, 8'h80, 1, 0, 1, "shr_step1");
      expect_at(k + 5, 8'h80, 1, 0, 1, "shr_wait2");
      expect_at(k + 6, 8'hC0, 0, 1, 0, "shr_done");
      expect_at(k + 7, 8'hC0, 0, 0, 0, "shr_idle");
      done_q.push_back(8'hC0);
      tick(1);
      start_n = 1'b1; mode = 2'b00; steps = 3'd1; period = 4'd0;
      tick(7);

      // Rotate right 0x81, S=5, P=3, abort after the first step
      load0_n = 1'b0; d0 = 8'h81; k = edge_n + 1;
      expect_at(k, 8'h81, 0, 0, 0, "load_81");
      tick(1);
      load0_n = 1'b1; start_n = 1'b0; mode = 2'b01; ser_in = 1'b0; steps = 3'd5; period = 4'd3;
      k = edge_n + 1;
      expect_at(k,     8'h81, 1, 0, 0, "ror_start");
      expect_at(k + 3, 8'h81, 1, 0, 0, "ror_wait");
      expect_at(k + 4, 8'hC0, 1, 0, 1, "ror_step1");
      expect_at(k + 5, 8'hC0, 0, 0, 1, "abort_idle");
      expect_at(k + 9, 8'hC0, 0, 0, 1, "abort_hold");
      tick(1);
      start_n = 1'b1;
      tick(1);
      start_n = 1'b0;
      tick(1);
      start_n = 1'b1;
      tick(2);
      abort_n = 1'b0;
      tick(1);
      abort_n = 1'b1;
      tick(4);

      // Zero-step command: immediate done, data unchanged
      start_n = 1'b0; mode = 2'b00; steps = 3'd0; period = 4'd5;
      k = edge_n + 1;
      expect_at(k,     8'hC0, 0, 1, 1, "s0_done");
      expect_at(k + 1, 8'hC0, 0, 0, 1, "s0_idle");
      done_q.push_back(8'hC0);
      tick(1);
      start_n = 1'b1;
      tick(1);

      // Clear and load0 together mid-command cancel it
      start_n = 1'b0; mode = 2'b00; steps = 3'd7; period = 4'd1;
      k = edge_n + 1;
      expect_at(k,     8'hC0, 1, 0, 1, "clr_run_start");
      expect_at(k + 2, 8'h81, 1, 0, 1, "clr_run_step1");
      expect_at(k + 3, 8'h00, 0, 0, 1, "clear_cancel");
      expect_at(k + 4, 8'h3C, 0, 0, 1, "load1_3c");
      expect_at(k + 5, 8'h3C, 0, 0, 1, "rst_between_edges");
      expect_at(k + 6, 8'h00, 0, 0, 0, "rst_applied");
      tick(1);
      start_n = 1'b1;
      tick(2);
      clear_n = 1'b0; load0_n = 1'b0; d0 = 8'h55;
      tick(1);
      clear_n = 1'b1; load0_n = 1'b1; load1_n = 1'b0; d1 = 8'h3C;
      tick(1);
      load1_n = 1'b1;
      @(posedge clk);
      #1 rst = 1'b1;
      tick(2);
      rst = 1'b0;

      for (int i = 0; i < 50 && exp_q.size() > 0; i++) tick(1);
      if (exp_q.size() > 0) begin
         n_checks = n_checks + 1;
         n_fail = n_fail + 1;
         $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      end
      tick(20);
      n_checks = n_checks + 1;
      if (done_q.size() != 0) begin
         n_fail = n_fail + 1;
         $display("FAIL done_count: %0d done pulses missing, required 0", done_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
